crypto_sequencer: RTL and testbench

Sequences one encryption on the target's crypto core. A host write sets the USB-memory "go" byte. The block latches key and plaintext from the host memory bus into the core, pulses start, and drives the capture trigger while the core runs. It then stores the ciphertext and status for host readback. It sits between the USB register memory (on the `clk_sys` domain) and the crypto core.

---
 rtl/crypto_seq_pkg.sv | 26 ++
 rtl/cdc_pulse_sync.sv | 39 +++
 rtl/crypto_sequencer.sv | 159 +++++++++++++++
 tb/tb_crypto_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_seq_pkg.sv
// ---------------------------------------------------------------------------
// crypto_seq_pkg
// Shared definitions for the crypto sequencer:
//   state_t         - sequencer FSM states
//   ST_*            - bit positions inside the 8-bit status word
//   DEFAULT_TIMEOUT - default WAIT-state cycle budget
// ---------------------------------------------------------------------------
package crypto_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_PENDING = 3;

    localparam int DEFAULT_TIMEOUT = 65535;

endpackage

// File: rtl/cdc_pulse_sync.sv
// ---------------------------------------------------------------------------
// cdc_pulse_sync
// Brings an asynchronous level into the clk domain through a two-flop
// synchronizer and emits a registered one-cycle pulse on each rising edge.
// Ports:
//   clk      in  destination clock
//   rst_n    in  asynchronous active-low reset
//   async_in in  level from another clock domain / host register
//   pulse    out one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module cdc_pulse_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [1:0] sync_reg;
    logic       prev_reg;
    logic       pulse_reg;

    // sync_reg[1] is the first metastability-safe copy; prev_reg delays it
    // by one cycle for edge detection. The pulse itself is registered so no
    // downstream logic sees a combinational path from the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b00;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], async_in};
            prev_reg  <= sync_reg[1];
            pulse_reg <= sync_reg[1] & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/crypto_sequencer.sv
// ---------------------------------------------------------------------------
// crypto_sequencer
// Runs one encryption on the crypto core per host "go" edge: latches key and
// plaintext, strobes load/start, holds the capture trigger while the core
// runs, then stores the ciphertext and status for host readback.
// Ports:
//   clk_sys, reset_n       clock, asynchronous active-low reset
//   go_in                  host go bit (asynchronous level)
//   key_in, pt_in          key / plaintext from host memory bus
//   core_key, core_pt      registered copies presented to the core
//   core_load, core_start  one-cycle strobes to the core
//   core_done, core_ct     core result handshake and ciphertext
//   ct_out                 captured ciphertext
//   status                 {4'b0, go_pending, timeout, done, busy}
//   op_count               completed-operation counter (wraps)
//   trigger                capture trigger, high while the core runs
// ---------------------------------------------------------------------------
module crypto_sequencer
    import crypto_seq_pkg::*;
#(
    parameter int KEY_W     = 128,
    parameter int PT_W      = 128,
    parameter int CT_W      = 128,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int TIMEOUT_W = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             go_in,
    input  logic [KEY_W-1:0] key_in,
    input  logic [PT_W-1:0]  pt_in,
    output logic [KEY_W-1:0] core_key,
    output logic [PT_W-1:0]  core_pt,
    output logic             core_load,
    output logic             core_start,
    input  logic             core_done,
    input  logic [CT_W-1:0]  core_ct,
    output logic [CT_W-1:0]  ct_out,
    output logic [7:0]       status,
    output logic [15:0]      op_count,
    output logic             trigger
);

    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state_reg;
    logic [KEY_W-1:0]     core_key_reg;
    logic [PT_W-1:0]      core_pt_reg;
    logic                 core_load_reg;
    logic                 core_start_reg;
    logic                 trigger_reg;
    logic [CT_W-1:0]      ct_out_reg;
    logic [15:0]          op_count_reg;
    logic                 done_reg;
    logic                 timeout_reg;
    logic                 pending_reg;
    logic [TIMEOUT_W-1:0] wait_cnt_reg;
    logic                 go_rise;

    cdc_pulse_sync u_go_sync (
        .clk      (clk_sys),
        .rst_n    (reset_n),
        .async_in (go_in),
        .pulse    (go_rise)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            core_key_reg   <= '0;
            core_pt_reg    <= '0;
            core_load_reg  <= 1'b0;
            core_start_reg <= 1'b0;
            trigger_reg    <= 1'b0;
            ct_out_reg     <= '0;
            op_count_reg   <= '0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            pending_reg    <= 1'b0;
            wait_cnt_reg   <= '0;
        end else begin
            // Strobes are high only in the cycle after the transition that
            // sets them.
            core_load_reg  <= 1'b0;
            core_start_reg <= 1'b0;

            // A request arriving while busy is remembered once; more edges
            // before relaunch collapse into the same pending request.
            if (go_rise && (state_reg != S_IDLE)) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (go_rise || pending_reg) begin
                        state_reg     <= S_LOAD;
                        core_key_reg  <= key_in;
                        core_pt_reg   <= pt_in;
                        core_load_reg <= 1'b1;
                        pending_reg   <= 1'b0;
                        done_reg      <= 1'b0;
                        timeout_reg   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state_reg      <= S_START;
                    core_start_reg <= 1'b1;
                    trigger_reg    <= 1'b1;
                end
                S_START: begin
                    state_reg    <= S_WAIT;
                    wait_cnt_reg <= '0;
                end
                S_WAIT: begin
                    // core_done takes priority over an expiring budget.
                    if (core_done) begin
                        state_reg   <= S_CAPTURE;
                        trigger_reg <= 1'b0;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg   <= S_ERROR;
                        trigger_reg <= 1'b0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + TIMEOUT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    state_reg    <= S_IDLE;
                    ct_out_reg   <= core_ct;
                    op_count_reg <= op_count_reg + 16'd1;
                    done_reg     <= 1'b1;
                end
                S_ERROR: begin
                    state_reg   <= S_IDLE;
                    timeout_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign core_key   = core_key_reg;
    assign core_pt    = core_pt_reg;
    assign core_load  = core_load_reg;
    assign core_start = core_start_reg;
    assign trigger    = trigger_reg;
    assign ct_out     = ct_out_reg;
    assign op_count   = op_count_reg;

    always_comb begin
        status             = 8'h00;
        status[ST_BUSY]    = (state_reg != S_IDLE);
        status[ST_DONE]    = done_reg;
        status[ST_TIMEOUT] = timeout_reg;
        status[ST_PENDING] = pending_reg;
    end

endmodule

// File: tb/tb_crypto_sequencer.sv
// ---------------------------------------------------------------------------
// tb_crypto_sequencer
// Randomized scoreboard bench. The driver predicts, from the go/done timing
// rules, when each load, start and completion must appear and what the host
// must read back; a monitor pops those expectations as the DUT presents them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_crypto_sequencer;

    localparam int KW = 128;
    localparam int T  = 20;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          go_in   = 1'b0;
    logic [KW-1:0] key_in  = '0;
    logic [KW-1:0] pt_in   = '0;
    logic [KW-1:0] core_key;
    logic [KW-1:0] core_pt;
    logic          core_load;
    logic          core_start;
    logic          core_done = 1'b0;
    logic [KW-1:0] core_ct   = '0;
    logic [KW-1:0] ct_out;
    logic [7:0]    status;
    logic [15:0]   op_count;
    logic          trigger;

    crypto_sequencer #(
        .KEY_W     (KW),
        .PT_W      (KW),
        .CT_W      (KW),
        .TIMEOUT   (T),
        .TIMEOUT_W (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .go_in      (go_in),
        .key_in     (key_in),
        .pt_in      (pt_in),
        .core_key   (core_key),
        .core_pt    (core_pt),
        .core_load  (core_load),
        .core_start (core_start),
        .core_done  (core_done),
        .core_ct    (core_ct),
        .ct_out     (ct_out),
        .status     (status),
        .op_count   (op_count),
        .trigger    (trigger)
    );

    always #5 clk_sys = ~clk_sys;

    // cyc == number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    localparam int EV_LOAD  = 0;
    localparam int EV_START = 1;
    localparam int EV_DONE  = 2;

    typedef struct {
        int            kind;
        int            at;
        logic [KW-1:0] key;
        logic [KW-1:0] pt;
        logic [KW-1:0] ct;
        int            st;
        int            opc;
        int            trig;
    } ev_t;

    ev_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    // reference state the host should read back
    logic [KW-1:0] m_ct  = '0;
    logic [15:0]   m_opc = '0;

    task automatic chk_i(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [KW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void push_ev(input int kind, input int at, input logic [KW-1:0] key,
                                    input logic [KW-1:0] pt, input logic [KW-1:0] ct,
                                    input int st, input int opc, input int trig);
        ev_t e;
        e.kind = kind; e.at = at; e.key = key; e.pt = pt; e.ct = ct;
        e.st = st; e.opc = opc; e.trig = trig;
        sb.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    task automatic take(input int kind, output bit ok, output ev_t e);
        ok = 1'b0;
        e.kind = -1; e.at = 0; e.key = '0; e.pt = '0; e.ct = '0;
        e.st = 0; e.opc = 0; e.trig = 0;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d at cyc=%0d exp=none", kind, cyc);
        end else begin
            e = sb.pop_front();
            chk_i("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    initial begin
        int  trig_cnt;
        bit  prev_busy;
        bit  ok;
        ev_t e;
        trig_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                trig_cnt  = 0;
                prev_busy = 1'b0;
            end else begin
                if (trigger) trig_cnt++;
                if (core_load) begin
                    take(EV_LOAD, ok, e);
                    if (ok) begin
                        chk_i("load_cycle", cyc, e.at);
                        chk_w("core_key", core_key, e.key);
                        chk_w("core_pt", core_pt, e.pt);
                        $display("LOAD  cyc=%0d key=%h", cyc, core_key);
                    end
                end
                if (core_start) begin
                    take(EV_START, ok, e);
                    if (ok) chk_i("start_cycle", cyc, e.at);
                end
                if (prev_busy && !status[0]) begin
                    take(EV_DONE, ok, e);
                    if (ok) begin
                        chk_i("done_cycle", cyc, e.at);
                        chk_w("ct_out", ct_out, e.ct);
                        chk_i("status", int'(status), e.st);
                        chk_i("op_count", int'(op_count), e.opc);
                        chk_i("trigger_low", int'(trigger), 0);
                        chk_i("trigger_len", trig_cnt, e.trig);
                        $display("DONE  cyc=%0d status=%02h op_count=%0d ct=%h", cyc, status, op_count, ct_out);
                    end
                    trig_cnt = 0;
                end
                prev_busy = status[0];
            end
        end
    end

    // ---------------- driver / reference model ----------------
    // One operation whose LOAD edge is L. d = cycles from the core_start
    // cycle to the core_done pulse (0 = core never answers). n_extra extra go
    // edges are sent during WAIT. rst_mid aborts the run with reset in WAIT.
    task automatic run_op(input int L, input logic [KW-1:0] key, input logic [KW-1:0] pt,
                          input logic [KW-1:0] ct, input int d, input int n_extra,
                          input bit rst_mid, output int C);
        int s, m, st;
        bit cap;
        s   = L + 1;
        cap = (d >= 1) && (d <= T);
        m   = cap ? (s + d + 1) : (s + 1 + T);
        C   = m + 1;
        key_in  = key;
        pt_in   = pt;
        core_ct = ct;
        push_ev(EV_LOAD, L, key, pt, '0, 0, 0, 0);
        push_ev(EV_START, s, '0, '0, '0, 0, 0, 0);
        if (!rst_mid) begin
            if (cap) begin
                m_opc = m_opc + 16'd1;
                m_ct  = ct;
            end
            st = cap ? 8'h02 : 8'h04;
            if (n_extra > 0) st = st | 8'h08;
            push_ev(EV_DONE, C, '0, '0, m_ct, st, int'(m_opc), m - s);
        end
        while (1) begin
            @(negedge clk_sys);
            if (cyc == L) begin
                key_in = rnd128();
                pt_in  = rnd128();
            end
            core_done = (d > 0) && (cyc == s + d);
            go_in = ((n_extra >= 1) && (cyc == s + 4 || cyc == s + 5)) ||
                    ((n_extra >= 2) && (cyc == s + 9 || cyc == s + 10));
            if (n_extra > 0 && cyc == s + 9) chk_i("pending_while_busy", int'(status), 8'h09);
            if (rst_mid && cyc == s + 3) begin
                reset_n = 1'b0;
                #1;
                chk_w("rst_core_key", core_key, '0);
                chk_w("rst_core_pt", core_pt, '0);
                chk_w("rst_ct_out", ct_out, '0);
                chk_i("rst_status", int'(status), 0);
                chk_i("rst_op_count", int'(op_count), 0);
                chk_i("rst_strobes_trig", int'({core_load, core_start, trigger}), 0);
                $display("RESET cyc=%0d mid-operation", cyc);
                m_opc = '0;
                m_ct  = '0;
                break;
            end
            if (cyc == C) break;
        end
    endtask

    task automatic go_op(input logic [KW-1:0] key, input logic [KW-1:0] pt, input logic [KW-1:0] ct,
                         input int d, input int n_extra, input bit rst_mid, output int C);
        int L;
        repeat (4) @(negedge clk_sys);
        go_in = 1'b1;
        L = cyc + 4;    // go first sampled at cyc+1, LOAD three edges later
        run_op(L, key, pt, ct, d, n_extra, rst_mid, C);
    endtask

    initial begin
        int C, d, ne;
        bit pend;
        logic [KW-1:0] fk, fp, fc;
        fk = 128'h000102030405060708090a0b0c0d0e0f;
        fp = 128'h00112233445566778899aabbccddeeff;
        fc = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        repeat (3) @(negedge clk_sys);
        chk_i("reset_status", int'(status), 0);
        chk_i("reset_op_count", int'(op_count), 0);
        chk_w("reset_ct_out", ct_out, '0);
        chk_i("reset_strobes_trig", int'({core_load, core_start, trigger}), 0);
        reset_n = 1'b1;

        go_op(fk, fp, fc, 10, 0, 1'b0, C);                   // reference vector
        go_op(rnd128(), rnd128(), rnd128(), 0, 0, 1'b0, C);   // core never answers
        go_op(rnd128(), rnd128(), rnd128(), T, 0, 1'b0, C);   // done on last WAIT cycle
        go_op(rnd128(), rnd128(), rnd128(), T + 1, 0, 1'b0, C); // one cycle too late
        go_op(rnd128(), rnd128(), rnd128(), 1, 0, 1'b0, C);   // shortest operation
        go_op(rnd128(), rnd128(), rnd128(), 12, 1, 1'b0, C);  // queued second request
        run_op(C + 1, rnd128(), rnd128(), rnd128(), 5, 0, 1'b0, C);
        go_op(rnd128(), rnd128(), rnd128(), 0, 2, 1'b0, C);   // two edges, one relaunch
        run_op(C + 1, rnd128(), rnd128(), rnd128(), 3, 0, 1'b0, C);

        pend = 1'b0;
        for (int i = 0; i < 12; i++) begin
            d  = int'($urandom_range(0, 24));
            ne = 0;
            if (i < 11 && (d == 0 || d >= 12) && $urandom_range(0, 2) == 0)
                ne = int'($urandom_range(1, 2));
            if (pend) run_op(C + 1, rnd128(), rnd128(), rnd128(), d, ne, 1'b0, C);
            else      go_op(rnd128(), rnd128(), rnd128(), d, ne, 1'b0, C);
            pend = (ne > 0);
        end

        go_op(rnd128(), rnd128(), rnd128(), 0, 0, 1'b1, C);   // reset during WAIT
        core_done = 1'b0;
        go_in     = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        go_op(rnd128(), rnd128(), rnd128(), 7, 0, 1'b0, C);   // op_count back to 1

        @(negedge clk_sys);
        force dut.op_count_reg = 16'hffff;
        @(negedge clk_sys);
        release dut.op_count_reg;
        @(negedge clk_sys);
        chk_i("op_count_preload", int'(op_count), 16'hffff);
        m_opc = 16'hffff;
        go_op(rnd128(), rnd128(), rnd128(), 4, 0, 1'b0, C);   // wraps to 0

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_sys);
        chk_i("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
